// File: rtl/score_counter_bcd.sv
// Purpose : registered multi-digit BCD score counter with seven-segment decode and optional high score.
// Latency : 1 cycle from the edge sampling incr/clear to bcd/seg/ovf; hi_bcd trails bcd by one more cycle.
// Backpressure: none; incr is accepted on every edge. At max it wraps (SATURATE=0) or holds (SATURATE=1).
//
// Parameters:
//   DIGITS   - number of BCD digits (1..6)
//   SATURATE - 0 = wrap to zero after all nines, 1 = hold at all nines
//   BLANK_LZ - 1 = blank leading-zero digits on seg (digit 0 always shown)
// Ports:
//   clk    - clock, all state changes on rising edge
//   reset  - asynchronous active-low reset
//   incr   - add one to the score
//   clear  - synchronous zero of the score, wins over incr
//   bcd    - score, digit i at [4i+3:4i], digit 0 = ones
//   seg    - active-low segments, digit i at [7i+6:7i], bit0 = a .. bit6 = g
//   ovf    - one-cycle pulse on wrap, or on an increment refused at max
//   hi_bcd - high score (same packing as bcd); constant 0 unless SCORE_HISCORE_EN is defined
// Optional feature macro: SCORE_HISCORE_EN enables the high-score register and comparator.

module score_counter_bcd #(
  parameter int DIGITS   = 3,
  parameter int SATURATE = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  incr,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   hi_bcd
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] bcd_inc;
  logic                at_max;

  assign at_max = (bcd == ALL_NINES);

  // Ripple-carry BCD increment: each digit rolls 9->0 and passes the carry up.
  // From all nines this yields all zeros, which is exactly the wrap value.
  always_comb begin : inc_chain
    logic carry;
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      bcd <= '0;
      ovf <= 1'b0;
    end else if (incr) begin
      // ovf flags both the wrap and the refused increment in saturate mode.
      ovf <= at_max;
      if (!(at_max && (SATURATE != 0))) begin
        bcd <= bcd_inc;
      end
    end else begin
      ovf <= 1'b0;
    end
  end

  // Active-low segment codes, bit order g..a.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Walk from the most significant digit down; a digit is a leading zero
  // until the first nonzero digit has been seen. Digit 0 is always shown.
  always_comb begin : seg_decode
    logic seen;
    seg  = '1;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      if ((BLANK_LZ != 0) && !seen && (i != 0)) begin
        seg[7*i +: 7] = 7'b1111111;
      end else begin
        seg[7*i +: 7] = seg_code(bcd[4*i +: 4]);
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  // With every digit held in 0..9, a plain unsigned compare of the packed
  // BCD vectors orders scores exactly like their decimal values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_bcd <= '0;
    end else if (bcd > hi_bcd) begin
      hi_bcd <= bcd;
    end
  end
`else
  assign hi_bcd = '0;
`endif

endmodule

// File: doc/score_counter_bcd.md
SCORE_COUNTER_BCD -- requirements
Module: score_counter_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of BCD digits, legal range 1..6.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap at max, 1 = hold at max.
REQ-003 SHALL have parameter BLANK_LZ, default 1: 1 = blank leading-zero digits on seg.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset (reset=0 resets).
REQ-006 SHALL have port incr  input  1: add one to score on this rising edge.
REQ-007 SHALL have port clear  input  1: synchronous zeroing of score.
REQ-008 SHALL have port bcd  output  4*DIGITS: score, digit i at bits [4i+3:4i], digit 0 = ones.
REQ-009 SHALL have port seg  output  7*DIGITS: active-low seven-segment, digit i at [7i+6:7i], bit0=a ... bit6=g.
REQ-010 SHALL have port ovf  output  1: one-cycle pulse on wrap (SATURATE=0) or on a rejected increment at max (SATURATE=1).
REQ-011 SHALL have port hi_bcd  output  4*DIGITS: high score, same packing as bcd.

Function
REQ-012 SHALL be a registered BCD counter; each digit held in 0..9 at all times, never 10..15.
REQ-013 SHALL, on a clk edge with incr=1 and clear=0, increment digit 0; a digit at 9 goes to 0 and carries into the next digit, rippling through all digits in the same edge.
REQ-014 SHALL make the new score visible on bcd and seg one cycle after the edge that samples incr (latency 1).
REQ-015 SHALL, with SATURATE=0 and all digits 9, wrap all digits to 0 on incr and assert ovf for exactly the following cycle.
REQ-016 SHALL, with SATURATE=1 and all digits 9, leave the score unchanged on incr and assert ovf for exactly the following cycle.
REQ-017 SHALL keep ovf at 0 in every cycle not covered by REQ-015/REQ-016; back-to-back incr at max with SATURATE=1 produces ovf high on consecutive cycles.
REQ-018 SHALL give clear priority over incr: clear=1 forces all digits to 0 on the next edge, ovf=0, incr ignored that edge.
REQ-019 SHALL derive seg combinationally from registered bcd with active-low codes (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 SHALL, with BLANK_LZ=1, drive 1111111 on every digit above the most significant nonzero digit; digit 0 is never blanked (score 0 shows "0").
REQ-021 SHALL, with BLANK_LZ=0, display every digit including leading zeros.
REQ-022 SHALL treat the score as an unsigned decimal integer for all comparisons (most significant digit first).

Reset
REQ-023 SHALL, while reset=0, immediately force bcd=0, ovf=0, hi_bcd=0, independent of clk.
REQ-024 SHALL, on reset asserted mid-increment, discard the pending increment; the first edge after reset=1 behaves as from score 0.
REQ-025 SHALL NOT clear hi_bcd via clear; only reset zeroes hi_bcd.

Configuration
REQ-026 SHALL compile the high-score register in only when macro SCORE_HISCORE_EN is defined.
REQ-027 SHALL, with SCORE_HISCORE_EN defined, load hi_bcd with bcd on every edge where registered bcd > hi_bcd, so hi_bcd trails a new record by one cycle and never decreases (including across wrap and clear).
REQ-028 SHALL, with SCORE_HISCORE_EN undefined, tie hi_bcd to constant 0 and contain no high-score storage or comparator.

Verification
REQ-029 Bench SHALL cover: DIGITS=3, reset then 15 incr pulses -> bcd=0x015, seg digit1=1111001, digit0=0010010, digit2=1111111 (BLANK_LZ=1).
REQ-030 Bench SHALL cover: DIGITS=2, SATURATE=0, load 99 via 99 incr, one more incr -> bcd=0x00, ovf high exactly one cycle, seg digit0=1000000, digit1=1111111.
REQ-031 Bench SHALL cover: DIGITS=2, SATURATE=1, at 99 apply 3 consecutive incr -> bcd stays 0x99, ovf high 3 consecutive cycles.
REQ-032 Bench SHALL cover: incr and clear both high at score 0x042 -> next cycle bcd=0x000, ovf=0.
REQ-033 Bench SHALL cover: SCORE_HISCORE_EN defined, count to 0x027, clear, count to 0x005 -> hi_bcd=0x027; reset=0 asynchronously mid-cycle -> bcd and hi_bcd 0 before next edge.
REQ-034 Bench SHALL cover: SCORE_HISCORE_EN undefined, count to 0x027 -> hi_bcd=0x000 throughout.
